core_sequencer: RTL and testbench



---
 rtl/core_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_core_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: per-core control FSM. It walks one block of threads through
// FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE for every instruction,
// and owns the shared PC, the retired-instruction counter, the sticky
// divergence flag and the memory-wait watchdog.
//
// Interface protocol: there is no valid/ready handshake on this block. Every
// neighbour publishes a level-style status that is sampled on each rising edge:
// fetcher_state == FETCHED releases FETCH, and per-lane lsu_state
// REQUESTING/WAITING holds WAIT. core_state is the registered FSM state and is
// itself the status that downstream units consume (it doubles as debug output).
module core_sequencer #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int WAIT_TIMEOUT      = 255
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
  input  logic [2:0]                             fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
  input  logic                                   decoded_pc_mux,
  input  logic                                   decoded_ret,
  output logic [2:0]                             core_state,
  output logic [PC_BITS-1:0]                     current_pc,
  output logic [THREADS_PER_BLOCK-1:0]           active_mask,
  output logic                                   done,
  output logic                                   timeout,
  output logic                                   diverged,
  output logic [15:0]                            retired_count
);

  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int WDW = $clog2(WAIT_TIMEOUT + 1);

  // DECODE and UPDATE encodings are keyed on by the decoder; do not renumber.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  state_t state_q;
  state_t state_d;

  logic [WDW-1:0]                   wd_q;
  logic [WDW-1:0]                   wd_next;
  logic                             wd_expired;
  logic                             blocked;
  logic [THREADS_PER_BLOCK-1:0]     start_mask;
  logic [PC_BITS-1:0]               chosen_pc;
  logic                             lanes_differ;

  // Control strobes decoded from the current state.
  logic latch_block;
  logic wd_clear;
  logic wd_step;
  logic retire;
  logic pc_load;
  logic done_set;
  logic timeout_set;

  // Lane activity from the requested thread count; counts above the lane
  // total naturally light every lane, so no separate clamp is needed.
  always_comb begin
    start_mask = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      start_mask[i] = (TCW'(i) < thread_count);
    end
  end

  // A lane blocks WAIT while it is REQUESTING (01) or WAITING (10); idle lanes never block.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (active_mask[i] && (lsu_state[2*i+1] ^ lsu_state[2*i])) begin
        blocked = 1'b1;
      end
    end
  end

  // Pick the lowest active lane's next PC and flag any active lane that disagrees.
  always_comb begin
    chosen_pc    = next_pc[0 +: PC_BITS];
    lanes_differ = 1'b0;
    for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
      if (active_mask[i]) begin
        chosen_pc = next_pc[PC_BITS*i +: PC_BITS];
      end
    end
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (active_mask[i] && (next_pc[PC_BITS*i +: PC_BITS] != chosen_pc)) begin
        lanes_differ = 1'b1;
      end
    end
  end

  // Watchdog value after counting the current WAIT cycle.
  always_comb begin
    wd_next    = wd_q + 1'b1;
    wd_expired = (wd_next >= WDW'(WAIT_TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in WAIT a release takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = (start_mask == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT: begin
        if (!blocked)        state_d = S_EXECUTE;
        else if (wd_expired) state_d = S_DONE;
      end
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE:  state_d = decoded_ret ? S_DONE : S_FETCH;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/strobe decode from the current state.
  always_comb begin
    latch_block = 1'b0;
    wd_clear    = 1'b0;
    wd_step     = 1'b0;
    retire      = 1'b0;
    pc_load     = 1'b0;
    done_set    = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_block = 1'b1;
          done_set    = (start_mask == '0);
        end
      end
      S_REQUEST: wd_clear = 1'b1;
      S_WAIT: begin
        wd_step = 1'b1;
        if (blocked && wd_expired) begin
          done_set    = 1'b1;
          timeout_set = 1'b1;
        end
      end
      S_UPDATE: begin
        retire = 1'b1;
        if (decoded_ret) done_set = 1'b1;
        else             pc_load  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers: PC, lane mask, watchdog, retire counter, sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_pc    <= '0;
      active_mask   <= '0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      diverged      <= 1'b0;
      retired_count <= '0;
      wd_q          <= '0;
    end else begin
      if (latch_block) begin
        active_mask <= start_mask;
        current_pc  <= '0;
      end
      if (pc_load) begin
        current_pc <= chosen_pc;
        if (decoded_pc_mux && lanes_differ) diverged <= 1'b1;
      end
      if (wd_clear)     wd_q <= '0;
      else if (wd_step) wd_q <= wd_next;
      if (retire && (retired_count != 16'hFFFF)) retired_count <= retired_count + 16'd1;
      if (done_set)    done    <= 1'b1;
      if (timeout_set) timeout <= 1'b1;
    end
  end

  assign core_state = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: builds a per-cycle stimulus stream together with the
// expected outputs from an instruction-level model, then replays it against
// core_sequencer and compares every output after every edge.
module tb_core_sequencer;

  localparam int T   = 4;
  localparam int PB  = 8;
  localparam int WT  = 8;
  localparam int TCW = $clog2(T) + 1;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [2:0] S_DONE    = 3'b111;

  logic            clk;
  logic            reset;
  logic            start;
  logic [TCW-1:0]  thread_count;
  logic [2:0]      fetcher_state;
  logic [2*T-1:0]  lsu_state;
  logic [PB*T-1:0] next_pc;
  logic            decoded_pc_mux;
  logic            decoded_ret;
  logic [2:0]      core_state;
  logic [PB-1:0]   current_pc;
  logic [T-1:0]    active_mask;
  logic            done;
  logic            timeout;
  logic            diverged;
  logic [15:0]     retired_count;

  core_sequencer #(
    .THREADS_PER_BLOCK (T),
    .PC_BITS           (PB),
    .WAIT_TIMEOUT      (WT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .thread_count   (thread_count),
    .fetcher_state  (fetcher_state),
    .lsu_state      (lsu_state),
    .next_pc        (next_pc),
    .decoded_pc_mux (decoded_pc_mux),
    .decoded_ret    (decoded_ret),
    .core_state     (core_state),
    .current_pc     (current_pc),
    .active_mask    (active_mask),
    .done           (done),
    .timeout        (timeout),
    .diverged       (diverged),
    .retired_count  (retired_count)
  );

  typedef struct packed {
    logic            rst;
    logic            start;
    logic [TCW-1:0]  tc;
    logic [2:0]      fetch;
    logic [2*T-1:0]  lsu;
    logic [PB*T-1:0] npc;
    logic            mux;
    logic            ret;
  } stim_t;

  typedef struct packed {
    logic [2:0]    st;
    logic [PB-1:0] pc;
    logic [T-1:0]  mask;
    logic          done;
    logic          to;
    logic          div;
    logic [15:0]   ret_cnt;
  } exp_t;

  typedef struct {
    int              f;
    int              b;
    logic            use_lsu;
    logic [2*T-1:0]  lsu_blk;
    logic [PB*T-1:0] npc;
    logic            mux;
    logic            ret;
    int              rst_wait;
  } instr_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int checks;
  int failures;
  int cycle;

  // Instruction-level model of the block's architectural state.
  logic [2:0]    m_st;
  logic [PB-1:0] m_pc;
  logic [T-1:0]  m_mask;
  logic          m_done;
  logic          m_to;
  logic          m_div;
  logic [15:0]   m_ret;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = 1'b0;
    s.start = 1'($urandom_range(0, 1));
    s.tc    = TCW'($urandom_range(0, 7));
    s.fetch = 3'($urandom_range(0, 7));
    s.lsu   = (2*T)'($urandom);
    for (int i = 0; i < T; i++) s.npc[PB*i +: PB] = PB'($urandom);
    s.mux   = 1'($urandom_range(0, 1));
    s.ret   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic instr_t def_instr();
    instr_t in;
    in.f        = 1;
    in.b        = 0;
    in.use_lsu  = 1'b0;
    in.lsu_blk  = '0;
    in.npc      = '0;
    in.mux      = 1'b0;
    in.ret      = 1'b0;
    in.rst_wait = 0;
    return in;
  endfunction

  function automatic instr_t rand_instr();
    instr_t        in;
    logic [PB-1:0] base;
    in   = def_instr();
    base = PB'($urandom);
    in.f = $urandom_range(1, 3);
    in.b = ($urandom_range(0, 3) == 0) ? $urandom_range(5, WT + 2) : $urandom_range(0, 4);
    for (int i = 0; i < T; i++)
      in.npc[PB*i +: PB] = ($urandom_range(0, 3) == 0) ? PB'($urandom) : base;
    in.mux = 1'($urandom_range(0, 1));
    in.ret = ($urandom_range(0, 5) == 0);
    return in;
  endfunction

  // Record one cycle: the inputs and the outputs expected after its edge.
  task automatic push(input stim_t s);
    exp_t e;
    e.st      = m_st;
    e.pc      = m_pc;
    e.mask    = m_mask;
    e.done    = m_done;
    e.to      = m_to;
    e.div     = m_div;
    e.ret_cnt = m_ret;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_pc = '0; m_mask = '0;
    m_done = 1'b0; m_to = 1'b0; m_div = 1'b0; m_ret = '0;
  endtask

  task automatic reset_cycle();
    stim_t s;
    s = rand_stim();
    s.rst = 1'b1;
    model_reset();
    push(s);
  endtask

  task automatic idle_cycle();
    stim_t s;
    s = rand_stim();
    s.start = 1'b0;
    push(s);
  endtask

  task automatic start_block(input int tc);
    stim_t s;
    int    n;
    s = rand_stim();
    s.start = 1'b1;
    s.tc    = TCW'(tc);
    n = (tc > T) ? T : tc;
    for (int i = 0; i < T; i++) m_mask[i] = (i < n);
    m_pc = '0;
    if (n == 0) begin m_st = S_DONE; m_done = 1'b1; end
    else        m_st = S_FETCH;
    push(s);
  endtask

  task automatic done_cycles(input int n, input bit force_start);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s = rand_stim();
      if (force_start) s.start = 1'b1;
      push(s);
    end
  endtask

  // One instruction from FETCH through UPDATE, or until watchdog/reset ends it.
  task automatic add_instr(input instr_t in);
    stim_t         s;
    int            lane;
    bit            fin;
    bit            found;
    logic [PB-1:0] pick;
    if (m_st != S_FETCH) return;
    for (int k = 1; k <= in.f; k++) begin
      s = rand_stim();
      if (k == in.f) begin s.fetch = 3'b010; m_st = S_DECODE; end
      else if (s.fetch == 3'b010) s.fetch = 3'b001;
      push(s);
    end
    s = rand_stim(); m_st = S_REQUEST; push(s);
    s = rand_stim(); m_st = S_WAIT;    push(s);
    fin = 1'b0;
    for (int k = 1; k <= WT && !fin; k++) begin
      s = rand_stim();
      if (in.rst_wait == k) begin
        s.rst = 1'b1;
        model_reset();
        push(s);
        fin = 1'b1;
      end else if (k <= in.b) begin
        if (in.use_lsu) s.lsu = in.lsu_blk;
        else begin
          lane = $urandom_range(0, T - 1);
          while (!m_mask[lane]) lane = $urandom_range(0, T - 1);
          s.lsu[2*lane +: 2] = 2'($urandom_range(1, 2));
        end
        if (k == WT) begin
          m_st = S_DONE; m_done = 1'b1; m_to = 1'b1; fin = 1'b1;
        end
        push(s);
      end else begin
        if (in.use_lsu) s.lsu = in.lsu_blk;
        for (int i = 0; i < T; i++)
          if (m_mask[i]) s.lsu[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        m_st = S_EXECUTE;
        push(s);
        fin = 1'b1;
      end
    end
    if (m_st != S_EXECUTE) return;
    s = rand_stim(); m_st = S_UPDATE; push(s);
    s = rand_stim();
    s.npc = in.npc; s.mux = in.mux; s.ret = in.ret;
    if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
    if (in.ret) begin
      m_st = S_DONE; m_done = 1'b1;
    end else begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < T; i++)
        if (m_mask[i] && !found) begin pick = in.npc[PB*i +: PB]; found = 1'b1; end
      if (in.mux)
        for (int i = 0; i < T; i++)
          if (m_mask[i] && in.npc[PB*i +: PB] != pick) m_div = 1'b1;
      m_pc = pick;
      m_st = S_FETCH;
    end
    push(s);
  endtask

  // Scenario list, then replay with per-cycle checks.
  initial begin
    stim_t  s;
    exp_t   e;
    instr_t in;
    checks = 0; failures = 0; cycle = 0;
    reset = 1'b1; start = 1'b0; thread_count = '0; fetcher_state = '0;
    lsu_state = '0; next_pc = '0; decoded_pc_mux = 1'b0; decoded_ret = 1'b0;
    model_reset();

    reset_cycle(); reset_cycle(); idle_cycle(); idle_cycle();

    // Basic run: four lanes, fetch takes two cycles, no memory wait.
    start_block(4);
    in = def_instr(); in.f = 2; in.npc = {8'd1, 8'd1, 8'd1, 8'd1};
    add_instr(in);
    reset_cycle();

    // Memory wait: lane1 waiting, inactive lanes 2-3 stuck requesting.
    start_block(2);
    in = def_instr(); in.b = 5; in.use_lsu = 1'b1; in.lsu_blk = 8'b01_01_10_00;
    in.npc = {8'd3, 8'd3, 8'd7, 8'd7};
    add_instr(in);
    add_instr(rand_instr());
    reset_cycle();

    // Watchdog: lane0 never leaves REQUESTING; start in DONE is ignored.
    start_block(1);
    in = def_instr(); in.b = 1000; in.use_lsu = 1'b1; in.lsu_blk = 8'b00_00_00_01;
    add_instr(in);
    done_cycles(3, 1'b1);
    reset_cycle(); idle_cycle();

    // Release on the last watchdog cycle wins over the timeout.
    start_block(4);
    in = def_instr(); in.b = WT - 1; in.npc = {8'd4, 8'd4, 8'd4, 8'd4};
    add_instr(in);
    reset_cycle();

    // Divergence among active lanes.
    start_block(3);
    in = def_instr(); in.mux = 1'b1; in.npc = {8'd77, 8'd9, 8'd5, 8'd5};
    add_instr(in);
    reset_cycle();

    // Only the inactive lane disagrees, then RET ends the block.
    start_block(3);
    in = def_instr(); in.mux = 1'b1; in.npc = {8'd9, 8'd5, 8'd5, 8'd5};
    add_instr(in);
    in = def_instr(); in.f = 2; in.ret = 1'b1; in.npc = {8'd1, 8'd2, 8'd3, 8'd4};
    add_instr(in);
    done_cycles(3, 1'b1);
    reset_cycle();

    // Zero threads goes straight to DONE; oversize count lights all lanes.
    start_block(0);
    done_cycles(2, 1'b1);
    reset_cycle();
    start_block(7);
    add_instr(rand_instr());
    reset_cycle();

    // Reset asserted mid-WAIT.
    start_block(2);
    in = def_instr(); in.b = 4; in.rst_wait = 3;
    add_instr(in);
    idle_cycle();

    // Randomized blocks.
    for (int blk = 0; blk < 10; blk++) begin
      reset_cycle();
      idle_cycle();
      start_block($urandom_range(0, 7));
      for (int n = 0; n < 6; n++) add_instr(rand_instr());
      if (m_st == S_DONE) done_cycles(2, 1'b0);
    end
    reset_cycle();

    // Replay: inputs applied just after an edge, outputs checked just after the next.
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      reset          = s.rst;
      start          = s.start;
      thread_count   = s.tc;
      fetcher_state  = s.fetch;
      lsu_state      = s.lsu;
      next_pc        = s.npc;
      decoded_pc_mux = s.mux;
      decoded_ret    = s.ret;
      @(posedge clk);
      #1;
      cycle++;
      check("core_state",    32'(core_state),    32'(e.st));
      check("current_pc",    32'(current_pc),    32'(e.pc));
      check("active_mask",   32'(active_mask),   32'(e.mask));
      check("done",          32'(done),          32'(e.done));
      check("timeout",       32'(timeout),       32'(e.to));
      check("diverged",      32'(diverged),      32'(e.div));
      check("retired_count", 32'(retired_count), 32'(e.ret_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
